lvds_timing_ctrl: RTL and testbench

Frame-timing controller and pixel scheduler that sequences the LVDS panel serializer. It is a J1 memory-mapped peripheral that holds the panel timing registers and runs horizontal/vertical counters. It pops pixels from an upstream line FIFO and drives 24-bit RGB plus DE/HSYNC/VSYNC into the LVDS transmitter, which serializes them onto the channel/clock pairs.

---
 rtl/lvds_timing_ctrl.sv | 156 +++++++++++++++
 tb/tb_lvds_timing_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/lvds_timing_ctrl.sv
// Panel frame-timing controller: J1-mapped timing registers, h/v counters and
// a pixel scheduler that feeds RGB + DE/HSYNC/VSYNC to the LVDS transmitter.
module lvds_timing_ctrl #(
  parameter int CW           = 12,
  parameter int H_ACTIVE_DEF = 1024,
  parameter int H_TOTAL_DEF  = 1344,
  parameter int V_ACTIVE_DEF = 768,
  parameter int V_TOTAL_DEF  = 806,
  parameter int HSW_DEF      = 136,
  parameter int VSW_DEF      = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_in,
  input  logic        cs,
  input  logic [3:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] d_out,
  input  logic        pix_rdy,
  input  logic [23:0] pix_data,
  output logic        pix_pop,
  output logic [23:0] rgb_out,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]    state;
  logic          en, tp, underflow;
  logic [CW-1:0] h_active, h_total, v_active, v_total, hsw, vsw;
  logic [CW-1:0] sh_ha, sh_ht, sh_va, sh_vt, sh_hsw, sh_vsw;
  logic [CW-1:0] ha_c, ht_c, va_c, vt_c;
  logic [CW-1:0] hcnt, vcnt;
  logic          run, h_end, v_end, sh_load;
  logic          de_c, hs_c, vs_c, fs_c, uf_set, st_rd;
  logic [23:0]   rgb_c;
  logic [15:0]   rd_val;
  logic          unused_din;

  assign unused_din = ^d_in[15:CW];

  // Degenerate timings are repaired only on the way into the shadows.
  always_comb begin
    ha_c = (h_active == '0) ? CW'(1) : h_active;
    ht_c = (h_total <= ha_c) ? ha_c + CW'(1) : h_total;
    va_c = (v_active == '0) ? CW'(1) : v_active;
    vt_c = (v_total <= va_c) ? va_c + CW'(1) : v_total;
  end

  assign run     = (state == S_RUN);
  assign h_end   = (hcnt == sh_ht - CW'(1));
  assign v_end   = (vcnt == sh_vt - CW'(1));
  assign sh_load = en && ((state == S_IDLE) || (h_end && v_end));

  assign de_c = run && (hcnt < sh_ha) && (vcnt < sh_va);
  assign hs_c = run && (hcnt >= sh_ha) && ({1'b0, hcnt} < {1'b0, sh_ha} + {1'b0, sh_hsw});
  assign vs_c = run && (vcnt >= sh_va) && ({1'b0, vcnt} < {1'b0, sh_va} + {1'b0, sh_vsw});
  assign fs_c = run && (hcnt == '0) && (vcnt == '0);

  assign pix_pop = de_c && !tp && pix_rdy;
  assign uf_set  = de_c && !tp && !pix_rdy;
  assign st_rd   = cs && rd && (addr == 4'h8);

  always_comb begin
    rgb_c = '0;
    if (de_c) begin
      if (tp)           rgb_c = {hcnt[7:0], vcnt[7:0], hcnt[7:0] ^ vcnt[7:0]};
      else if (pix_rdy) rgb_c = pix_data;
    end
  end

  always_comb begin
    rd_val = '0;
    case (addr)
      4'h0: rd_val = {14'b0, tp, en};
      4'h1: rd_val = 16'(h_active);
      4'h2: rd_val = 16'(h_total);
      4'h3: rd_val = 16'(v_active);
      4'h4: rd_val = 16'(v_total);
      4'h5: rd_val = 16'(hsw);
      4'h6: rd_val = 16'(vsw);
      4'h8: rd_val = {13'b0, underflow, (vcnt >= sh_va), run};
      4'h9: rd_val = 16'(vcnt);
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en <= 1'b0; tp <= 1'b0; underflow <= 1'b0; d_out <= '0;
      h_active <= CW'(H_ACTIVE_DEF); h_total <= CW'(H_TOTAL_DEF);
      v_active <= CW'(V_ACTIVE_DEF); v_total <= CW'(V_TOTAL_DEF);
      hsw <= CW'(HSW_DEF); vsw <= CW'(VSW_DEF);
    end else begin
      if (cs && wr) begin
        case (addr)
          4'h0: begin en <= d_in[0]; tp <= d_in[1]; end
          4'h1: h_active <= d_in[CW-1:0];
          4'h2: h_total  <= d_in[CW-1:0];
          4'h3: v_active <= d_in[CW-1:0];
          4'h4: v_total  <= d_in[CW-1:0];
          4'h5: hsw      <= d_in[CW-1:0];
          4'h6: vsw      <= d_in[CW-1:0];
          default: ;
        endcase
      end
      if (cs && rd) d_out <= rd_val;
      // A fresh underflow beats the read-to-clear.
      if (uf_set)     underflow <= 1'b1;
      else if (st_rd) underflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_ha <= CW'(H_ACTIVE_DEF); sh_ht <= CW'(H_TOTAL_DEF);
      sh_va <= CW'(V_ACTIVE_DEF); sh_vt <= CW'(V_TOTAL_DEF);
      sh_hsw <= CW'(HSW_DEF); sh_vsw <= CW'(VSW_DEF);
    end else if (sh_load) begin
      sh_ha <= ha_c; sh_ht <= ht_c; sh_va <= va_c; sh_vt <= vt_c;
      sh_hsw <= hsw; sh_vsw <= vsw;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE; hcnt <= '0; vcnt <= '0;
    end else if (state == S_IDLE) begin
      hcnt <= '0; vcnt <= '0;
      if (en) state <= S_RUN;
    end else if (h_end) begin
      hcnt <= '0;
      if (v_end) begin
        vcnt <= '0;
        if (!en) state <= S_IDLE;
      end else begin
        vcnt <= vcnt + CW'(1);
      end
    end else begin
      hcnt <= hcnt + CW'(1);
    end
  end

  // Video outputs lag the counters by one cycle; all-zero whenever idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      de <= 1'b0; hsync <= 1'b0; vsync <= 1'b0; frame_start <= 1'b0; rgb_out <= '0;
    end else begin
      de <= de_c; hsync <= hs_c; vsync <= vs_c; frame_start <= fs_c; rgb_out <= rgb_c;
    end
  end
endmodule

// File: tb/tb_lvds_timing_ctrl.sv
// Directed bench for lvds_timing_ctrl: register table, small-panel frames,
// underflow, shadowing, stop-at-end-of-frame, test pattern and async reset.
module tb_lvds_timing_ctrl;
  localparam int CW = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] d_in = '0;
  logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [3:0]  addr = '0;
  logic [15:0] d_out;
  logic        pix_rdy = 1'b0;
  logic [23:0] pix_data = '0;
  logic        pix_pop;
  logic [23:0] rgb_out;
  logic        de, hsync, vsync, frame_start;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lvds_timing_ctrl #(.CW(CW)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
    .d_out(d_out), .pix_rdy(pix_rdy), .pix_data(pix_data), .pix_pop(pix_pop),
    .rgb_out(rgb_out), .de(de), .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
  );

  typedef struct {
    bit          is_wr;
    logic [3:0]  a;
    logic [15:0] d;
    logic [15:0] e;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [15:0] e, input string nm);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    chk(nm, 32'(d_out), 32'(e));
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_de"}, 32'(de), 32'(0));
    chk({nm, "_hsync"}, 32'(hsync), 32'(0));
    chk({nm, "_vsync"}, 32'(vsync), 32'(0));
    chk({nm, "_fs"}, 32'(frame_start), 32'(0));
    chk({nm, "_rgb"}, 32'(rgb_out), 32'(0));
    chk({nm, "_pop"}, 32'(pix_pop), 32'(0));
  endtask

  task automatic wait_fs();
    int n = 0;
    while (!frame_start && n < 300) begin
      pix_rdy = 1'b1; pix_data = 24'($urandom);
      @(negedge clk);
      n++;
    end
    chk("wait_frame_start", 32'(frame_start), 32'(1));
  endtask

  // Called at the negedge that shows frame_start. v_active=2, v_total=4,
  // hsw=2, vsw=1 for every frame. Pops are tallied for counter values
  // 1..N, the last being the following frame's (0,0).
  task automatic run_frame(input int ht, input int ha, input int bad, input bit tpat,
                           input bit stop, input int op_k, input logic [3:0] op_a,
                           input logic [15:0] op_d, input int exp_pops, input string tag);
    int n = ht * 4;
    int pops = 0;
    for (int k = 0; k < n; k++) begin
      int h = k % ht;
      int v = k / ht;
      int nk = (k + 1) % n;
      logic [7:0] hb = 8'(h);
      logic [7:0] vb = 8'(v);
      logic e_de = (h < ha) && (v < 2);
      logic e_hs = (h >= ha) && (h < ha + 2);
      logic e_vs = (v == 2);
      logic nrdy;
      logic e_pop;
      logic [23:0] e_rgb = '0;
      if (e_de) begin
        if (tpat)         e_rgb = {hb, vb, hb ^ vb};
        else if (pix_rdy) e_rgb = pix_data;
      end
      chk($sformatf("%s_de_k%0d", tag, k), 32'(de), 32'(e_de));
      chk($sformatf("%s_hsync_k%0d", tag, k), 32'(hsync), 32'(e_hs));
      chk($sformatf("%s_vsync_k%0d", tag, k), 32'(vsync), 32'(e_vs));
      chk($sformatf("%s_fs_k%0d", tag, k), 32'(frame_start), 32'(k == 0));
      chk($sformatf("%s_rgb_k%0d", tag, k), 32'(rgb_out), 32'(e_rgb));
      cs = 1'b0; wr = 1'b0;
      if (k == op_k) begin cs = 1'b1; wr = 1'b1; addr = op_a; d_in = op_d; end
      nrdy = ((nk / ht) != bad);
      pix_rdy = nrdy;
      pix_data = 24'($urandom);
      #1;
      e_pop = (stop && k == n - 1) ? 1'b0 :
              (((nk % ht) < ha) && ((nk / ht) < 2) && nrdy && !tpat);
      chk($sformatf("%s_pop_k%0d", tag, k), 32'(pix_pop), 32'(e_pop));
      if (pix_pop) pops++;
      @(negedge clk);
    end
    cs = 1'b0; wr = 1'b0;
    chk({tag, "_pop_count"}, 32'(pops), 32'(exp_pops));
  endtask

  initial begin
    int fs_seen;
    tbl.push_back('{0, 4'h2, 16'h0000, 16'd1344});
    tbl.push_back('{0, 4'h8, 16'h0000, 16'h0000});
    tbl.push_back('{0, 4'h1, 16'h0000, 16'd1024});
    tbl.push_back('{0, 4'h3, 16'h0000, 16'd768});
    tbl.push_back('{0, 4'h4, 16'h0000, 16'd806});
    tbl.push_back('{0, 4'h5, 16'h0000, 16'd136});
    tbl.push_back('{0, 4'h6, 16'h0000, 16'd6});
    tbl.push_back('{0, 4'h0, 16'h0000, 16'h0000});
    tbl.push_back('{0, 4'h9, 16'h0000, 16'h0000});
    tbl.push_back('{1, 4'h7, 16'hFFFF, 16'h0000});
    tbl.push_back('{0, 4'h7, 16'h0000, 16'h0000});
    tbl.push_back('{0, 4'hF, 16'h0000, 16'h0000});
    tbl.push_back('{1, 4'h1, 16'hF004, 16'h0000});
    tbl.push_back('{0, 4'h1, 16'h0000, 16'h0004});
    tbl.push_back('{1, 4'h2, 16'd8, 16'h0000});
    tbl.push_back('{0, 4'h2, 16'h0000, 16'd8});
    tbl.push_back('{1, 4'h3, 16'd2, 16'h0000});
    tbl.push_back('{1, 4'h4, 16'd4, 16'h0000});
    tbl.push_back('{1, 4'h5, 16'd2, 16'h0000});
    tbl.push_back('{1, 4'h6, 16'd1, 16'h0000});
    tbl.push_back('{0, 4'h6, 16'h0000, 16'd1});
    tbl.push_back('{1, 4'h0, 16'hFFF2, 16'h0000});
    tbl.push_back('{0, 4'h0, 16'h0000, 16'h0002});
    tbl.push_back('{1, 4'h0, 16'h0000, 16'h0000});
    tbl.push_back('{0, 4'h0, 16'h0000, 16'h0000});

    repeat (3) @(negedge clk);
    chk_quiet("in_reset");
    chk("in_reset_dout", 32'(d_out), 32'(0));
    rst = 1'b1;
    @(negedge clk);
    chk_quiet("post_reset");

    foreach (tbl[i]) begin
      if (tbl[i].is_wr) bus_write(tbl[i].a, tbl[i].d);
      else bus_read(tbl[i].a, tbl[i].e, $sformatf("reg_rd_%0d_a%0h", i, tbl[i].a));
    end

    // h_active=4 h_total=8 v_active=2 v_total=4 hsw=2 vsw=1 are now programmed.
    bus_write(4'h0, 16'h0001);
    wait_fs();
    run_frame(8, 4, -1, 1'b0, 1'b0, -1, 4'h0, 16'h0, 8, "frm");
    run_frame(8, 4, 1, 1'b0, 1'b0, -1, 4'h0, 16'h0, 4, "uflow");
    bus_read(4'h8, 16'h0005, "status_uflow");
    bus_read(4'h8, 16'h0001, "status_cleared");

    wait_fs();
    run_frame(8, 4, -1, 1'b0, 1'b0, 5, 4'h1, 16'd6, 8, "midwr");
    run_frame(8, 6, -1, 1'b0, 1'b1, 10, 4'h0, 16'h0, 11, "stop");
    chk_quiet("idle");
    bus_read(4'h8, 16'h0000, "status_idle");
    fs_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_start || de) fs_seen++;
    end
    chk("idle_no_activity", 32'(fs_seen), 32'(0));

    bus_write(4'h1, 16'd4);
    bus_write(4'h2, 16'd3);
    bus_write(4'h0, 16'h0003);
    wait_fs();
    run_frame(5, 4, -1, 1'b1, 1'b0, -1, 4'h0, 16'h0, 0, "tpat");

    bus_read(4'h2, 16'd3, "h_total_raw");
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk_quiet("async_rst");
    chk("async_rst_dout", 32'(d_out), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus_read(4'h1, 16'd1024, "rst_h_active");
    bus_read(4'h2, 16'd1344, "rst_h_total");
    bus_read(4'h5, 16'd136, "rst_hsw");
    bus_read(4'h0, 16'h0000, "rst_ctrl");
    bus_read(4'h8, 16'h0000, "rst_status");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
